// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate operation scheduler.
package gate_pkg;

  // Bitwise operation selector carried on each request channel.
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  // Scheduler control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } sched_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_logic_unit.sv
// Registered W-bit bitwise logic unit shared by all requesters.
module gate_logic_unit
  import gate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  op_e          i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  logic [W-1:0] y_q;
  logic [W-1:0] y_d;

  // Pure combinational evaluation of one gate operation.
  function automatic logic [W-1:0] gate_eval(input op_e op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next result: new evaluation when enabled, otherwise hold.
  always_comb begin
    y_d = y_q;
    if (i_en) begin
      y_d = gate_eval(i_op, i_a, i_b);
    end else begin
      y_d = y_q;
    end
  end

  // Result register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign o_y = y_q;

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one registered logic unit among N_REQ requesters.
module gate_op_scheduler
  import gate_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int IDW   = id_width(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic [2*N_REQ-1:0] i_req_op,
  input  logic [W*N_REQ-1:0] i_req_a,
  input  logic [W*N_REQ-1:0] i_req_b,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [W-1:0]       o_rsp_data,
  output logic               o_busy
);

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  op_e            op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;

  logic           found_s;
  logic [IDW-1:0] grant_s;
  logic [IDW:0]   scan_s;
  logic [N_REQ-1:0] ready_s;
  op_e            sel_op_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;
  logic [W-1:0]   y_s;
  logic           resp_s;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    scan_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_s = {1'b0, ptr_q} + (IDW+1)'(k);
      scan_s = (scan_s >= NREQ_W) ? (scan_s - NREQ_W) : scan_s;
      if (!found_s && i_req_valid[scan_s[IDW-1:0]]) begin
        found_s = 1'b1;
        grant_s = scan_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Select the winning requester's op and operands.
  always_comb begin
    sel_op_s = OP_AND;
    sel_a_s  = '0;
    sel_b_s  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      sel_op_s = (grant_s == IDW'(r)) ? op_e'(i_req_op[2*r +: 2]) : sel_op_s;
      sel_a_s  = (grant_s == IDW'(r)) ? i_req_a[W*r +: W] : sel_a_s;
      sel_b_s  = (grant_s == IDW'(r)) ? i_req_b[W*r +: W] : sel_b_s;
    end
  end

  // Next-state, operand capture and grant generation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    ready_s = '0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          for (int r = 0; r < N_REQ; r++) begin
            ready_s[r] = (grant_s == IDW'(r));
          end
          state_d = S_EXEC;
          id_d    = grant_s;
          op_d    = sel_op_s;
          a_d     = sel_a_s;
          b_d     = sel_b_s;
          ptr_d   = (grant_s == LAST_ID) ? '0 : (grant_s + IDW'(1));
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
          id_d    = '0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        id_d    = '0;
      end
    endcase
  end

  // Control and operand registers; reset discards any in-flight op.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  gate_logic_unit #(
    .W (W)
  ) u_logic (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (state_q == S_EXEC),
    .i_op    (op_q),
    .i_a     (a_q),
    .i_b     (b_q),
    .o_y     (y_s)
  );

  // Response fields are only exposed while in RESP and out of reset.
  assign resp_s      = (state_q == S_RESP) && i_rst_n;
  assign o_rsp_valid = resp_s;
  assign o_rsp_id    = resp_s ? id_q : '0;
  assign o_rsp_data  = resp_s ? y_s : '0;
  assign o_busy      = (state_q != S_IDLE) && i_rst_n;
  assign o_req_ready = i_rst_n ? ready_s : '0;

endmodule

// File: tb/tb_gate_op_scheduler.sv
module tb_gate_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tb_ptr = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_op_scheduler #(.N_REQ(4), .W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
    .o_busy      (busy)
  );

  function automatic logic [7:0] gate_model(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a | b);
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int arb_model(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_op[2*r +: 2] = op;
    req_a[8*r +: 8]  = a;
    req_b[8*r +: 8]  = b;
  endtask

  // One complete transaction from IDLE; checks grant, latency and response.
  task automatic run_op(input logic [3:0] vmask, input bit keep, input bit spacing);
    int   g;
    exp_t e;
    exp_t got;
    req_valid = vmask;
    #1;
    g = arb_model(vmask, tb_ptr);
    chk("grant_ready", 32'(req_ready), 32'(4'b0001 << g));
    chk("busy_idle", 32'(busy), 32'd0);
    if (spacing) chk("accept_spacing", 32'(cyc - last_acc), 32'd3);
    last_acc = cyc;
    e.id   = 2'(g);
    e.data = gate_model(req_op[2*g +: 2], req_a[8*g +: 8], req_b[8*g +: 8]);
    sb.push_back(e);
    tick;
    tb_ptr = (g == 3) ? 0 : g + 1;
    if (!keep) req_valid[g] = 1'b0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_ready", 32'(req_ready), 32'd0);
    tick;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("resp_id", 32'(rsp_id), 32'(got.id));
      chk("resp_data", 32'(rsp_data), 32'(got.data));
    end
    tick;
    chk("ret_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ret_rsp_id", 32'(rsp_id), 32'd0);
    chk("ret_rsp_data", 32'(rsp_data), 32'd0);
    chk("ret_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_op    = 8'h00;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_ready_forced", 32'(req_ready), 32'd0);
    tick;
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = 4'h0;
    rst_n     = 1'b1;
    tick;
    tb_ptr = 0;

    // Single ops on requester 0: AND then NOR, same operands.
    set_req(0, 2'b00, 8'hF0, 8'h3C);
    run_op(4'b0001, 1'b0, 1'b0);
    set_req(0, 2'b10, 8'hF0, 8'h3C);
    run_op(4'b0001, 1'b0, 1'b0);

    // Remaining ops: OR and NAND.
    set_req(1, 2'b01, 8'hA5, 8'h0F);
    run_op(4'b0010, 1'b0, 1'b0);
    set_req(3, 2'b11, 8'hFF, 8'h0F);
    run_op(4'b1000, 1'b0, 1'b0);

    // Fairness: all four held valid, round robin, one accept every 3 cycles.
    set_req(0, 2'b00, 8'h12, 8'hFF);
    set_req(1, 2'b01, 8'h34, 8'h01);
    set_req(2, 2'b10, 8'h56, 8'h08);
    set_req(3, 2'b11, 8'h78, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      run_op(4'hF, 1'b1, (i > 0));
    end
    req_valid = 4'h0;

    // Wrap/skip: grant 2 (ptr->3), only req1 -> grant 1 (ptr->2), then 1|2 -> 2.
    run_op(4'b0100, 1'b0, 1'b0);
    run_op(4'b0010, 1'b0, 1'b0);
    run_op(4'b0110, 1'b0, 1'b0);

    // Backpressure: response held 10 cycles with a new request waiting.
    set_req(0, 2'b01, 8'h81, 8'h18);
    req_valid = 4'b0001;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h1);
    tick;
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_rsp_data", 32'(rsp_data), 32'h99);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick;
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    tick;
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    tb_ptr = 1;

    // Reset mid-op: op discarded, ptr back to 0.
    set_req(1, 2'b00, 8'hFF, 8'hFF);
    req_valid = 4'b0010;
    tick;
    req_valid = 4'h0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tb_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("discard_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("discard_sb_empty", 32'(sb.size()), 32'd0);
    set_req(3, 2'b01, 8'h0F, 8'hF0);
    run_op(4'b1010, 1'b0, 1'b0);
    set_req(2, 2'b11, 8'h3C, 8'h0F);
    run_op(4'b0100, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
